// File: rtl/npu_seq_pkg.sv
// Shared types and default sizing for the NPU layer sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: state_e (4-bit FSM state, also exported on state_dbg),
// wreq_kind_e (loader request kind), default parameter values and the
// set of states guarded by the watchdog.
package npu_seq_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_C1_LOAD  = 4'd1,
    ST_C1_RUN   = 4'd2,
    ST_C1_SAVE  = 4'd3,
    ST_C2_LOAD  = 4'd4,
    ST_C2_RUN   = 4'd5,
    ST_C2_NEXT  = 4'd6,
    ST_FC_START = 4'd7,
    ST_FC_WAIT  = 4'd8,
    ST_FC_LOAD  = 4'd9,
    ST_FC_STEP  = 4'd10,
    ST_FC_DONE  = 4'd11,
    ST_ERR      = 4'd12
  } state_e;

  typedef enum logic [1:0] {
    WK_CONV1 = 2'd0,
    WK_CONV2 = 2'd1,
    WK_FC1   = 2'd2
  } wreq_kind_e;

  localparam int CHAN_DEF       = 10;
  localparam int C1_PIX_DEF     = 182;
  localparam int C2_PIX_DEF     = 132;
  localparam int FC1_GROUPS_DEF = 330;
  localparam int TIMEOUT_DEF    = 4096;
  localparam int WD_W           = 12;

  // States that wait on an external agent and can therefore hang.
  function automatic logic is_wait_state(input state_e s);
    return (s inside {ST_C1_LOAD, ST_C1_RUN, ST_C2_LOAD, ST_C2_RUN,
                      ST_FC_WAIT, ST_FC_LOAD});
  endfunction

endpackage

// File: rtl/npu_seq_watchdog.sv
// Dwell-time watchdog: counts cycles since the last clear, flags expiry.
// Latency: expire_o is combinational from the counter and clr_i (no input pins).
// Backpressure: none; the counter saturates at TIMEOUT-1 until cleared.
//
// Ports: clk, rst_ni (async active-low), clr_i (first cycle of a new state),
//        expire_o (high while the current state has lasted TIMEOUT cycles).
module npu_seq_watchdog
  import npu_seq_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst_ni,
  input  logic clr_i,
  output logic expire_o
);

  localparam logic [WD_W-1:0] LIMIT = WD_W'(TIMEOUT - 1);

  logic [WD_W-1:0] cnt_q;
  logic [WD_W-1:0] cnt_d;
  logic [WD_W-1:0] cnt_eff;

  // A clear restarts counting in the very cycle the new state is entered.
  always_comb begin
    cnt_eff = clr_i ? '0 : cnt_q;
    cnt_d   = (cnt_eff == LIMIT) ? cnt_eff : cnt_eff + WD_W'(1);
  end

  assign expire_o = (cnt_eff == LIMIT);

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/npu_layer_sequencer.sv
// Runs one NPU inference: conv1, CHAN conv2 passes, fcn start, fc1 group streaming.
// Latency: every output is a register; reactions appear one cycle after the input.
// Backpressure: loader requests hold valid/kind/idx until wreq_ack; fc1 waits on fcn_fc1_valid.
//
// Ports: clk, rst_ni; host start/abort, busy/done/err/result/state_dbg;
//        loader wreq_valid/kind/idx/ack; conv trigger/clear/layer/save_done/addr;
//        psum_clear; fcn start/fc1_next/fc1_valid/done/logit.
module npu_layer_sequencer
  import npu_seq_pkg::*;
#(
  parameter int CHAN       = CHAN_DEF,
  parameter int C1_PIX     = C1_PIX_DEF,
  parameter int C2_PIX     = C2_PIX_DEF,
  parameter int FC1_GROUPS = FC1_GROUPS_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst_ni,
  input  logic        start,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [23:0] result,
  output logic [3:0]  state_dbg,
  output logic        wreq_valid,
  output logic [1:0]  wreq_kind,
  output logic [8:0]  wreq_idx,
  input  logic        wreq_ack,
  output logic        conv_trigger,
  output logic        conv_clear,
  output logic        conv_layer,
  output logic        conv_save_done,
  input  logic [7:0]  conv_addr,
  output logic        psum_clear,
  output logic        fcn_start,
  output logic        fcn_fc1_next,
  input  logic        fcn_fc1_valid,
  input  logic        fcn_done,
  input  logic [23:0] fcn_logit
);

  localparam logic [7:0] C1_END   = 8'(C1_PIX);
  localparam logic [7:0] C2_END   = 8'(C2_PIX);
  localparam logic [8:0] LAST_CH  = 9'(CHAN - 1);
  localparam logic [8:0] N_GROUPS = 9'(FC1_GROUPS);

  state_e     state_q;
  state_e     prev_q;
  logic [8:0] ch_q;
  logic [8:0] grp_q;
  logic       wd_expire;

  // prev_q lags state_q by a cycle, so a mismatch marks the first cycle of a state.
  npu_seq_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk     (clk),
    .rst_ni  (rst_ni),
    .clr_i   (state_q != prev_q),
    .expire_o(wd_expire)
  );

  assign state_dbg = state_q;

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= ST_IDLE;
      prev_q         <= ST_IDLE;
      ch_q           <= '0;
      grp_q          <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
      result         <= '0;
      wreq_valid     <= 1'b0;
      wreq_kind      <= '0;
      wreq_idx       <= '0;
      conv_trigger   <= 1'b0;
      conv_clear     <= 1'b0;
      conv_layer     <= 1'b0;
      conv_save_done <= 1'b0;
      psum_clear     <= 1'b0;
      fcn_start      <= 1'b0;
      fcn_fc1_next   <= 1'b0;
    end else begin
      prev_q         <= state_q;
      // Single-cycle strobes default low; a branch below may raise one.
      done           <= 1'b0;
      conv_trigger   <= 1'b0;
      conv_clear     <= 1'b0;
      conv_save_done <= 1'b0;
      psum_clear     <= 1'b0;
      fcn_start      <= 1'b0;
      fcn_fc1_next   <= 1'b0;

      if (abort) begin
        // Same as reset except that the last logit survives.
        state_q    <= ST_IDLE;
        ch_q       <= '0;
        grp_q      <= '0;
        busy       <= 1'b0;
        err        <= 1'b0;
        wreq_valid <= 1'b0;
        wreq_kind  <= '0;
        wreq_idx   <= '0;
        conv_layer <= 1'b0;
      end else if (wd_expire && is_wait_state(state_q)) begin
        state_q    <= ST_ERR;
        err        <= 1'b1;
        busy       <= 1'b0;
        wreq_valid <= 1'b0;
        conv_layer <= 1'b0;
      end else begin
        unique case (state_q)
          ST_IDLE, ST_ERR: begin
            if (start) begin
              state_q    <= ST_C1_LOAD;
              psum_clear <= 1'b1;
              err        <= 1'b0;
              busy       <= 1'b1;
              ch_q       <= '0;
              grp_q      <= '0;
              wreq_valid <= 1'b1;
              wreq_kind  <= WK_CONV1;
              wreq_idx   <= '0;
              conv_layer <= 1'b0;
            end
          end
          ST_C1_LOAD: begin
            if (wreq_ack) begin
              state_q      <= ST_C1_RUN;
              wreq_valid   <= 1'b0;
              conv_trigger <= 1'b1;
            end
          end
          ST_C1_RUN: begin
            if (conv_addr == C1_END) begin
              state_q        <= ST_C1_SAVE;
              conv_clear     <= 1'b1;
              conv_save_done <= 1'b1;
            end
          end
          ST_C1_SAVE: begin
            state_q    <= ST_C2_LOAD;
            wreq_valid <= 1'b1;
            wreq_kind  <= WK_CONV2;
            wreq_idx   <= ch_q;
            conv_layer <= 1'b1;
          end
          ST_C2_LOAD: begin
            if (wreq_ack) begin
              state_q      <= ST_C2_RUN;
              wreq_valid   <= 1'b0;
              conv_trigger <= 1'b1;
            end
          end
          ST_C2_RUN: begin
            if (conv_addr == C2_END) begin
              state_q    <= ST_C2_NEXT;
              conv_clear <= 1'b1;
            end
          end
          ST_C2_NEXT: begin
            if (ch_q == LAST_CH) begin
              state_q    <= ST_FC_START;
              fcn_start  <= 1'b1;
              conv_layer <= 1'b0;
            end else begin
              state_q    <= ST_C2_LOAD;
              ch_q       <= ch_q + 9'd1;
              wreq_valid <= 1'b1;
              wreq_kind  <= WK_CONV2;
              wreq_idx   <= ch_q + 9'd1;
            end
          end
          ST_FC_START: state_q <= ST_FC_WAIT;
          ST_FC_WAIT: begin
            // fcn_done wins over a pending group request.
            if (fcn_done) begin
              state_q <= ST_FC_DONE;
              result  <= fcn_logit;
              done    <= 1'b1;
              busy    <= 1'b0;
            end else if (fcn_fc1_valid && (grp_q < N_GROUPS)) begin
              state_q    <= ST_FC_LOAD;
              wreq_valid <= 1'b1;
              wreq_kind  <= WK_FC1;
              wreq_idx   <= grp_q;
            end
          end
          ST_FC_LOAD: begin
            if (wreq_ack) begin
              state_q      <= ST_FC_STEP;
              wreq_valid   <= 1'b0;
              fcn_fc1_next <= 1'b1;
            end
          end
          ST_FC_STEP: begin
            state_q <= ST_FC_WAIT;
            grp_q   <= grp_q + 9'd1;
          end
          ST_FC_DONE: state_q <= ST_IDLE;
          default:    state_q <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
